// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder
//   Registered N-to-2^N decoder with enable. The output z is always either
//   all-zero or exactly one-hot.
//   - DIRECT mode: the decoded line follows x, one cycle later.
//   - SCAN mode: an internal index rotates through the lines. Each line stays
//     active for DWELL cycles.
//
// Parameters
//   N      index width (N >= 1). The output is 2^N lines wide.
//   DWELL  number of cycles each line stays active in SCAN mode (DWELL >= 1).
//
// Ports
//   clock  system clock; all state changes on the rising edge
//   reset  synchronous, active-high reset
//   x      DIRECT: line to activate. SCAN: start index, sampled on SCAN entry
//   e      enable; 0 forces all lines inactive
//   mode   0 = DIRECT, 1 = SCAN
//   hold   SCAN only: freezes the index and the dwell counter
//   mask   (ONEHOT_SCAN_MASK_EN builds only) mask[i] = 1 disables line i
//   z      registered one-hot output
//   idx    registered index of the active line (the last active line when z = 0)
//   wrap   one-cycle pulse when the scan passes from line 2^N-1 to line 0
//
// Optional feature
//   Define ONEHOT_SCAN_MASK_EN to add the mask port. Without it, every line
//   is always eligible.
module onehot_scan_decoder #(
  parameter int N     = 3,
  parameter int DWELL = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N-1:0]      x,
  input  logic              e,
  input  logic              mode,
  input  logic              hold,
`ifdef ONEHOT_SCAN_MASK_EN
  input  logic [2**N-1:0]   mask,
`endif
  output logic [2**N-1:0]   z,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int M  = 2 ** N;
  localparam int CW = (DWELL <= 1) ? 1 : $clog2(DWELL);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_MAX    = N'(M - 1);
  localparam logic [M-1:0]  LINE0      = M'(1);

  typedef enum logic [1:0] {S_IDLE, S_DIRECT, S_SCAN} state_t;

  typedef struct packed {
    logic         found;
    logic [N-1:0] idx;
    logic         passed;  // search crossed from line M-1 to line 0
  } seek_t;

  state_t         state_q, state_d;
  logic [M-1:0]   z_q, z_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           wrap_q, wrap_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [M-1:0]   elig;
  logic           step_now;
  seek_t          sk;

`ifdef ONEHOT_SCAN_MASK_EN
  assign elig = ~mask;
`else
  assign elig = '1;
`endif

  // Finds the first eligible line at or after start, searching upward
  // modulo M. The loop runs from the farthest candidate down, so the
  // nearest eligible line is the one that ends up in the result.
  function automatic seek_t seek(input logic [N-1:0] start, input logic [M-1:0] ok);
    seek_t        r;
    logic [N-1:0] c;
    r = '0;
    for (int k = M - 1; k >= 0; k--) begin
      c = start + N'(k);
      if (ok[c]) begin
        r.found  = 1'b1;
        r.idx    = c;
        r.passed = (int'(start) + k) >= M;
      end
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      z_q     <= '0;
      idx_q   <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      idx_q   <= idx_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (!e)         state_d = S_IDLE;
    else if (!mode) state_d = S_DIRECT;
    else            state_d = S_SCAN;
  end

  // The scan advances when it is not held and the dwell period has expired.
  assign step_now = !hold && (cnt_q == DWELL_LAST);

  // Output and datapath logic. The results are registered by the state
  // register above.
  always_comb begin
    z_d    = z_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    cnt_d  = cnt_q;
    sk     = '0;
    if (!e) begin
      z_d   = '0;
      cnt_d = '0;
    end else if (!mode) begin
      cnt_d = '0;
      idx_d = x;
      z_d   = elig[x] ? (LINE0 << x) : '0;
    end else if (state_q != S_SCAN) begin
      // SCAN entry. Any earlier scan position is discarded and the scan
      // restarts from x.
      cnt_d = '0;
      sk    = seek(x, elig);
      if (sk.found) begin
        idx_d  = sk.idx;
        z_d    = LINE0 << sk.idx;
        wrap_d = sk.passed;
      end else begin
        z_d = '0;
      end
    end else begin
      if (step_now) begin
        cnt_d = '0;
        sk    = seek(idx_q + N'(1), elig);
        if (sk.found) begin
          idx_d  = sk.idx;
          z_d    = LINE0 << sk.idx;
          wrap_d = (idx_q == IDX_MAX) || sk.passed;
        end else begin
          z_d = '0;
        end
      end else begin
        if (!hold) cnt_d = cnt_q + CW'(1);
        // A line that is masked while it is active turns off on the next
        // edge. The index holds.
        if (!elig[idx_q]) z_d = '0;
      end
    end
  end

  assign z    = z_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
- Parametrised, registered N-to-2^N decoder with enable; output z is one-hot or all-zero.
- Two modes: DIRECT, where the registered decode follows x, and SCAN, where an internal index steps through the outputs with a programmable dwell.
- Drives multiplexed displays, keypad rows and chip-select banks, where a strobe must rotate without a separate counter-plus-decoder pair.

Parameters:
- N, 3, input/index width; output width 2^N; N >= 1.
- DWELL, 1, clock cycles each line stays active in SCAN; DWELL >= 1.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- x  input  N  DIRECT: line to activate. SCAN: start index, sampled on SCAN entry.
- e  input  1  enable; 0 forces all outputs inactive.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- hold  input  1  SCAN only: freezes index and dwell counter.
- z  output  2^N  registered one-hot output, z[i] = 1 iff line i active.
- idx  output  N  registered index of the active line (last active line when z = 0).
- wrap  output  1  one-cycle pulse when the SCAN index wraps from 2^N-1 to 0.

Behaviour:
- Reset: reset = 1 at a rising edge sets z = 0, idx = 0, wrap = 0, dwell counter = 0, state = IDLE. Reset has priority over every other input.
- State machine (registered), evaluated each edge in priority order:
  - e = 0: next state IDLE; z <= 0; idx holds; wrap <= 0; dwell counter <= 0.
  - e = 1, mode = 0: next state DIRECT; z <= 1 << x; idx <= x; wrap <= 0; dwell counter <= 0.
  - e = 1, mode = 1, current state not SCAN (SCAN entry): idx <= x; z <= 1 << x; dwell counter <= 0; wrap <= 0.
  - e = 1, mode = 1, current state SCAN: step rules below.
- Latency: one cycle from input to z/idx in every mode. No combinational path from inputs to outputs.
- SCAN step:
  - hold = 1: idx, z and dwell counter unchanged; wrap <= 0.
  - hold = 0 and dwell counter < DWELL-1: dwell counter +1; idx and z unchanged.
  - hold = 0 and dwell counter = DWELL-1: dwell counter <= 0; idx <= (idx + 1) mod 2^N; z <= 1 << new idx.
  - wrap <= 1 on the same edge only if the old idx = 2^N-1; otherwise wrap <= 0.
- Dwell counter width: max(1, ceil(log2(DWELL))). With DWELL = 1 the index advances every cycle.
- Index arithmetic: N bits, modulo 2^N, natural wrap with no overflow flag.
- Mode switch mid-scan:
  - SCAN to DIRECT: DIRECT value applies on the next edge; the scan position is discarded.
  - DIRECT to SCAN: counts as SCAN entry and restarts from x.
- e dropped mid-scan: z = 0 next cycle. Re-enabling with mode = 1 is a SCAN entry from x, not a resume.
- x changes while in SCAN: ignored.
- Invariant: z is 0 or exactly one-hot at all times, and z != 0 implies z = 1 << idx.

Optional Feature:
- Macro: ONEHOT_SCAN_MASK_EN.
- With the macro defined, an extra port is added: mask  input  2^N  (mask[i] = 1 disables line i).
  - DIRECT with mask[x] = 1: z <= 0 and idx <= x.
  - SCAN entry or step: the target is the first unmasked index at or after the nominal target, searching upward modulo 2^N.
  - wrap pulses if the search passes from 2^N-1 to 0.
  - All lines masked: z <= 0, idx holds, wrap <= 0, dwell counter keeps running.
  - mask changes take effect at the next entry or step, except that a currently active line becoming masked is cleared (z <= 0) on the next edge.
- Without the macro: the port is absent and all lines are always eligible.

Test Plan:
- Reset check: assert reset 2 cycles with e = 1, mode = 1 -> z = 8'h00, idx = 0, wrap = 0 throughout; after release, first edge gives z = 1 << x.
- DIRECT sweep (N = 3): e = 1, mode = 0, x = 0..7 one per cycle -> z = 8'h01, 02, 04 ... 80 each one cycle later, idx = x. Then e = 0 -> z = 8'h00 next cycle, idx = 7.
- SCAN with dwell (N = 3, DWELL = 2): x = 6, mode = 1 -> z = 8'h40 for 2 cycles, then 8'h80 for 2 cycles, then 8'h01 with wrap = 1 for exactly the first of those cycles.
- Hold and priority: during SCAN at idx = 3, hold = 1 for 5 cycles -> z stays 8'h08, no wrap. Drop e with hold = 1 -> z = 0. Re-enable with x = 1 -> restart at 8'h02.
- Mode switch: SCAN at idx = 5, switch to mode = 0 with x = 2 -> z = 8'h04 next cycle. Back to mode = 1 -> scan restarts at 2.
- Mask (ONEHOT_SCAN_MASK_EN, DWELL = 1): mask = 8'b1010_0101, start x = 0 -> z sequence 8'h02, 08, 10, 40, 02 with wrap on the return to 02. Mask = 8'hFF -> z = 0, no wrap.
